sparse_mm_sequencer: RTL
========================

# sparse_mm_sequencer

Front-end controller for the 4x4 sparse systolic multiplier array. It holds the 16 B-matrix weights and derives the per-cell sparsity flags from them. It accepts A-matrix rows over a valid/ready handshake, skews each row's four elements into the array's diagonal timing, and tracks in-flight rows. It collects the four 9-bit column sums into a result FIFO with valid/ready output.

## Interface
- FIFO_DEPTH, 8: result FIFO entries; also caps rows in flight plus rows buffered (minimum 6).
- ARR_LAT, 5: cycles from the skew stage presenting element 0 to the array's bottom-row outputs being valid.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active low.
- b_wr  in  1  B weight write strobe, honoured only in LOAD.
- b_addr  in  4  weight index, row*4+col, row = A element index.
- b_data  in  8  weight value.
- b_commit  in  1  pulse: leave LOAD, enter RUN.
- b_reload  in  1  pulse: leave RUN, drain, return to LOAD.
- a_valid / a_ready  in / out  1  A row handshake.
- a_data  in  32  A row; [8k+7:8k] is element k (k = 0..3).
- res_valid / res_ready  out / in  1  result handshake.
- res_data  out  36  result row; [9c+8:9c] is column c.
- arr_m1i  out  4x8  skewed A elements to the array inputs m1i1..m1i4.
- arr_m2c  out  16x8  weights to m2c1..m2c16, registered, stable outside LOAD.
- arr_f  out  16  sparsity flags f11..f44. Bit i = 1 when weight i is nonzero (cell computes); 0 means cell bypasses.
- arr_o  in  4x9  array outputs o1..o4.
- state  out  2  current FSM state, for debug.

## Operation
- FSM states are LOAD=0, RUN=1, DRAIN=2. Reset enters LOAD.
- LOAD:
  - A b_wr writes the weight register at b_addr; arr_f[b_addr] updates on the same edge to (b_data != 0).
  - a_ready = 0.
  - b_commit moves to RUN. If b_wr and b_commit arrive on the same edge, the write lands first and the FSM then moves to RUN.
- RUN:
  - b_wr is ignored.
  - a_ready = (inflight + fifo_count < FIFO_DEPTH). This is the credit check that guarantees every row entering the array has a FIFO slot.
  - b_reload moves to DRAIN. A row accepted on the same edge still counts as in flight.
- DRAIN:
  - a_ready = 0 and b_wr is ignored.
  - Moves to LOAD when inflight == 0 and fifo_count == 0.
- Skew:
  - An accepted row is written into a 4-lane delay triangle. Element k reaches arr_m1i[k] k+1 cycles after the accepting edge, so element 0 is registered once.
  - Lanes with no valid data drive 0.
- In-flight tracking:
  - A valid bit shifts through a pipe of length ARR_LAT+1. It is set by the accept and captured into the FIFO as it exits.
  - At capture, arr_o is registered directly into the FIFO tail. inflight counts the set bits in that pipe.
- Arithmetic: column sums are passed through unmodified as 9 bits. Overflow is the array's concern; the sequencer applies no saturation.
- Result FIFO:
  - Order is preserved.
  - A simultaneous push and pop keeps the count unchanged.
  - The FIFO is never pushed when full; the credit check makes this impossible, and an assertion checks it.
- Reset behaviour (asynchronous):
  - All weights and arr_f clear to 0, and arr_m1i clears to 0.
  - The valid pipe, inflight count and FIFO clear; res_valid = 0, a_ready = 0, state = LOAD.
  - A reset mid-stream discards every in-flight and buffered row.

## Timing
- A row accepted at edge k produces res_valid at edge k+ARR_LAT+2, which is edge k+7 with the defaults, provided the FIFO is empty.
- Throughput is one row per cycle while res_ready is held high.
- a_ready is combinational from state and the counters; it never depends on a_valid.
- res_data / res_valid come straight from the FIFO head, with no added register stage.
- arr_m2c and arr_f change only in LOAD, so they are constant for every row processed in RUN.
- b_commit and b_reload are ignored in any state other than the one that names them.

## Structure
- Shared package `sparse_mm_pkg`:
  - constants N=4, DW=8, OW=9, ARR_LAT.
  - state enum.
  - row/result packing helpers for the 8k / 9c lane offsets.
- Sub-module `smm_result_fifo`, parameterised by width (36) and FIFO_DEPTH. It exposes count, full and empty.
- The sequencer top holds:
  - the FSM;
  - the weight registers and flag generation;
  - the skew triangle;
  - the valid pipe and credit logic.

## Test plan
- Flag generation:
  - In LOAD, write B = identity, with every other address left at 0.
  - Required: arr_f = 16'h8421, using cell order f11 at bit 0.
  - After b_commit, further b_wr attempts leave arr_m2c unchanged.
- Skew and latency:
  - Accept a_data = 32'h04030201 at edge k.
  - Required: arr_m1i[0]=1 at k+1, [1]=2 at k+2, [2]=3 at k+3, [3]=4 at k+4.
  - With a behavioural array model and B = identity, res_data = {9'd4, 9'd3, 9'd2, 9'd1} with res_valid at k+7.
- Backpressure:
  - Hold res_ready = 0 and stream rows back to back.
  - Required: exactly 8 rows accepted, then a_ready stays 0.
  - After releasing res_ready, all 8 results drain in order with no loss.
- Reload drain:
  - Issue b_reload with 3 rows in flight.
  - Required: state stays DRAIN until the 3 results pop, then returns to LOAD. a_ready = 0 throughout.
- Reset mid-stream:
  - Assert rst_n = 0 asynchronously with rows in flight and in the FIFO.
  - Required: res_valid, arr_f and arr_m1i drop to 0 immediately, and state = LOAD.
- Sparse row:
  - Run with B containing only weight 5 (row 1, col 1) = 8'h7F, then accept A = {8'd0, 8'd0, 8'd2, 8'd0}, i.e. element 1 = 2.
  - Required: res_data column 1 = 9'd254 and all other columns = 0.

Source files
------------

// File: rtl/sparse_mm_pkg.sv
// Shared constants, FSM encoding and lane packing helpers for the sparse
// matrix-multiply sequencer and its bench.
package sparse_mm_pkg;
  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int OW      = 9;
  localparam int ARR_LAT = 5;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Element k of an A row lives at [8k+7:8k].
  function automatic logic [DW-1:0] row_elem(input logic [N*DW-1:0] row, input int k);
    return row[k*DW +: DW];
  endfunction

  // Column c of a result row lives at [9c+8:9c].
  function automatic logic [N*OW-1:0] pack_result(input logic [N-1:0][OW-1:0] cols);
    logic [N*OW-1:0] r;
    for (int c = 0; c < N; c++) r[c*OW +: OW] = cols[c];
    return r;
  endfunction
endpackage

// File: rtl/sparse_mm_sequencer_if.sv
// A-row input and result output handshakes between the sequencer and its host.
interface sparse_mm_sequencer_if;
  import sparse_mm_pkg::*;

  logic               a_valid;
  logic               a_ready;
  logic [N*DW-1:0]    a_data;
  logic               res_valid;
  logic               res_ready;
  logic [N*OW-1:0]    res_data;

  modport master (output a_valid, a_data, res_ready, input a_ready, res_valid, res_data);
  modport slave  (input a_valid, a_data, res_ready, output a_ready, res_valid, res_data);
endinterface

// File: rtl/smm_result_fifo.sv
// Result FIFO: array storage written on push, head read straight from the array
// so the output carries no extra register stage.
module smm_result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wrap_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= wrap_inc(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end
endmodule

// File: rtl/sparse_mm_sequencer.sv
// Front end of the 4x4 sparse systolic array: weight store with sparsity flags,
// A-row diagonal skew, in-flight credit tracking and the result FIFO.
module sparse_mm_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int ARR_LAT    = 5
) (
  input  logic                                                       clk,
  input  logic                                                       rst_n,
  input  logic                                                       b_wr,
  input  logic [3:0]                                                 b_addr,
  input  logic [sparse_mm_pkg::DW-1:0]                               b_data,
  input  logic                                                       b_commit,
  input  logic                                                       b_reload,
  sparse_mm_sequencer_if.slave                                       bus,
  output logic [sparse_mm_pkg::N-1:0][sparse_mm_pkg::DW-1:0]         arr_m1i,
  output logic [sparse_mm_pkg::N*sparse_mm_pkg::N-1:0][sparse_mm_pkg::DW-1:0] arr_m2c,
  output logic [sparse_mm_pkg::N*sparse_mm_pkg::N-1:0]               arr_f,
  input  logic [sparse_mm_pkg::N-1:0][sparse_mm_pkg::OW-1:0]         arr_o,
  output logic [1:0]                                                 state
);
  import sparse_mm_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(ARR_LAT + 2);

  state_t          state_reg;
  logic [ARR_LAT:0] vpipe_reg;
  logic [IW-1:0]   inflight_reg;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            a_ready;
  logic            accept;
  logic            capture;
  logic [N*OW-1:0] capture_data;

  // Credit check: every row admitted already owns a FIFO slot.
  assign a_ready     = (state_reg == ST_RUN) &&
                       ((int'(inflight_reg) + int'(fifo_count)) < FIFO_DEPTH);
  assign bus.a_ready = a_ready;
  assign accept      = bus.a_valid && a_ready;
  assign capture     = vpipe_reg[ARR_LAT];
  assign capture_data = pack_result(arr_o);
  assign state       = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_LOAD;
    end else begin
      case (state_reg)
        ST_LOAD:  if (b_commit) state_reg <= ST_RUN;
        ST_RUN:   if (b_reload) state_reg <= ST_DRAIN;
        ST_DRAIN: if (inflight_reg == '0 && fifo_count == '0) state_reg <= ST_LOAD;
        default:  state_reg <= ST_LOAD;
      endcase
    end
  end

  for (genvar gi = 0; gi < N*N; gi++) begin : g_weight
    logic [DW-1:0] w_reg;
    logic          f_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        w_reg <= '0;
        f_reg <= 1'b0;
      end else if (state_reg == ST_LOAD && b_wr && b_addr == 4'(gi)) begin
        w_reg <= b_data;
        f_reg <= (b_data != '0);
      end
    end
    assign arr_m2c[gi] = w_reg;
    assign arr_f[gi]   = f_reg;
  end

  // Lane k is k+1 registers deep; idle cycles shift zeros in.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [gi:0][DW-1:0] lane_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_reg <= '0;
      end else begin
        lane_reg[0] <= accept ? row_elem(bus.a_data, gi) : '0;
        for (int j = 1; j <= gi; j++) lane_reg[j] <= lane_reg[j-1];
      end
    end
    assign arr_m1i[gi] = lane_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      vpipe_reg    <= {vpipe_reg[ARR_LAT-1:0], accept};
      inflight_reg <= inflight_reg + IW'(accept) - IW'(capture);
    end
  end

  smm_result_fifo #(.WIDTH(N*OW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (capture_data),
    .pop       (bus.res_ready),
    .head      (bus.res_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.res_valid = !fifo_empty;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(capture && fifo_full));
endmodule
